timer_cfg_seq: RTL and testbench

- APB master sequencer that owns the timer's APB slave port and runs a complete one-shot compare cycle.
- On `start` it programs divider, counter and compare registers, enables the interrupt, then waits for `tim_int`. It then clears and verifies the interrupt status and reports `done`/`err`.
- Sits between a simple command source (CPU-less test harness or system FSM) and the timer's APB slave.

---
 rtl/timer_pkg.sv | 76 +++++++
 rtl/timer_apb_master.sv | 85 ++++++++
 rtl/timer_cfg_seq.sv | 158 +++++++++++++++
 tb/tb_timer_cfg_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer configuration sequencer.
// Contents: timer register offsets, TCR bit positions, step indices,
// FSM state encodings, the APB request record and the step-table lookup.
package timer_pkg;

  localparam logic [11:0] ADDR_TCR   = 12'h000;
  localparam logic [11:0] ADDR_TDR0  = 12'h004;
  localparam logic [11:0] ADDR_TDR1  = 12'h008;
  localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
  localparam logic [11:0] ADDR_TCMP1 = 12'h010;
  localparam logic [11:0] ADDR_TIER  = 12'h014;
  localparam logic [11:0] ADDR_TISR  = 12'h018;

  localparam int TCR_TIMER_EN = 0;
  localparam int TCR_DIV_EN   = 1;
  localparam int TCR_DIV_LSB  = 8;

  localparam logic [31:0] TISR_MASK = 32'h0000_0001;

  localparam int STEP_W = 4;
  localparam logic [STEP_W-1:0] STEP_FIRST = 4'd0;
  localparam logic [STEP_W-1:0] STEP_ONE   = 4'd1;
  localparam logic [STEP_W-1:0] STEP_ARM   = 4'd7;  // last write before waiting
  localparam logic [STEP_W-1:0] STEP_CLR   = 4'd8;  // status clear after interrupt
  localparam logic [STEP_W-1:0] STEP_CHK   = 4'd9;  // status read-back

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT_INT,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } apb_phase_e;

  typedef struct packed {
    logic [11:0] addr;
    logic        write;
    logic [31:0] wdata;
  } apb_req_t;

  // Step table: one APB transfer per step index.
  function automatic apb_req_t step_req(input logic [STEP_W-1:0] step,
                                        input logic [63:0]       cmp,
                                        input logic              den,
                                        input logic [3:0]        dval);
    apb_req_t r;
    r.addr  = ADDR_TCR;
    r.write = 1'b1;
    r.wdata = '0;
    case (step)
      4'd1: r.addr = ADDR_TDR0;
      4'd2: r.addr = ADDR_TDR1;
      4'd3: begin r.addr = ADDR_TCMP0; r.wdata = cmp[31:0];  end
      4'd4: begin r.addr = ADDR_TCMP1; r.wdata = cmp[63:32]; end
      4'd5: begin r.addr = ADDR_TISR;  r.wdata = TISR_MASK;  end
      4'd6: begin r.addr = ADDR_TIER;  r.wdata = 32'h1;      end
      4'd7: begin
        r.addr                          = ADDR_TCR;
        r.wdata[TCR_DIV_LSB +: 4]       = dval;
        r.wdata[TCR_DIV_EN]             = den;
        r.wdata[TCR_TIMER_EN]           = 1'b1;
      end
      4'd8: begin r.addr = ADDR_TISR;  r.wdata = TISR_MASK;  end
      4'd9: begin r.addr = ADDR_TISR;  r.write = 1'b0;       end
      default: ;  // step 0: TCR = 0
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_apb_master.sv
// Single-transfer APB master engine.
// req_i in the cycle before SETUP launches a transfer using addr_i/wdata_i/
// write_i, which the caller holds stable until ack_o. A req_i on the ack
// cycle chains the next SETUP without an idle cycle.
// Ports: clk_i, rst_ni (async active-low); req_i, addr_i, wdata_i, write_i;
// APB psel/penable/pwrite/paddr/pwdata/pstrb out, prdata/pready/pslverr in;
// ack_o, rdata_o, slverr_o, timeout_o results (valid in the completing cycle).
module timer_apb_master
  import timer_pkg::*;
#(
  parameter int TO_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        write_i,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [11:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        slverr_o,
  output logic        timeout_o
);

  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  // to_q holds the ACCESS cycles already spent; the cycle that would bring
  // the total to all-ones is the last one allowed.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  apb_phase_e      phase_q, phase_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            in_access;

  assign in_access = (phase_q == PH_ACCESS);
  assign ack_o     = in_access & pready_i;
  assign slverr_o  = ack_o & pslverr_i;
  assign timeout_o = in_access & ~pready_i & (to_q == TO_LAST);
  assign rdata_o   = prdata_i;

  always_comb begin
    phase_d = phase_q;
    to_d    = to_q;
    case (phase_q)
      PH_IDLE:  if (req_i) phase_d = PH_SETUP;
      PH_SETUP: begin
        phase_d = PH_ACCESS;
        to_d    = '0;
      end
      PH_ACCESS: begin
        to_d = to_q + TO_ONE;
        if (pready_i)       phase_d = req_i ? PH_SETUP : PH_IDLE;
        else if (timeout_o) phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= PH_IDLE;
      to_q    <= '0;
    end else begin
      phase_q <= phase_d;
      to_q    <= to_d;
    end
  end

  // Bus fields are forced to zero whenever no transfer is in flight.
  assign psel_o    = (phase_q != PH_IDLE);
  assign penable_o = in_access;
  assign pwrite_o  = psel_o & write_i;
  assign paddr_o   = psel_o ? addr_i : 12'h000;
  assign pwdata_o  = pwrite_o ? wdata_i : 32'h0;
  assign pstrb_o   = pwrite_o ? 4'hF : 4'h0;

endmodule

// File: rtl/timer_cfg_seq.sv
// Timer configuration sequencer: on start, programs the timer over APB,
// waits for its interrupt, clears and verifies the status, reports done/err.
// Ports: sys_clk, sys_rst_n (async active-low); start/abort commands;
// cmp_val/div_en/div_val operands (captured on start); busy/done/err status;
// tim_* APB master port towards the timer slave; tim_int interrupt level.
module timer_cfg_seq
  import timer_pkg::*;
#(
  parameter int TO_W = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] cmp_val,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [11:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr,
  input  logic        tim_int
);

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [63:0]       cmp_q, cmp_d;
  logic              den_q, den_d;
  logic [3:0]        dval_q, dval_d;
  logic              err_q, err_d;

  logic        req;
  logic        ack, slverr, timeout;
  logic [31:0] rdata;
  apb_req_t    cur;

  assign cur = step_req(step_q, cmp_q, den_q, dval_q);

  timer_apb_master #(.TO_W(TO_W)) u_apb (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .req_i     (req),
    .addr_i    (cur.addr),
    .wdata_i   (cur.wdata),
    .write_i   (cur.write),
    .psel_o    (tim_psel),
    .penable_o (tim_penable),
    .pwrite_o  (tim_pwrite),
    .paddr_o   (tim_paddr),
    .pwdata_o  (tim_pwdata),
    .pstrb_o   (tim_pstrb),
    .prdata_i  (tim_prdata),
    .pready_i  (tim_pready),
    .pslverr_i (tim_pslverr),
    .ack_o     (ack),
    .rdata_o   (rdata),
    .slverr_o  (slverr),
    .timeout_o (timeout)
  );

  // req is raised in the cycle before each SETUP, so step_d already
  // selects the transfer the engine is about to present.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cmp_d   = cmp_q;
    den_d   = den_q;
    dval_d  = dval_q;
    err_d   = err_q;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          step_d  = STEP_FIRST;
          cmp_d   = cmp_val;
          den_d   = div_en;
          dval_d  = div_val;
          err_d   = 1'b0;
          req     = 1'b1;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (ack) begin
          if (slverr) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (step_q == STEP_CHK) begin
            if (|(rdata & TISR_MASK)) err_d = 1'b1;
            state_d = ST_DONE;
          end else if (step_q == STEP_ARM) begin
            state_d = ST_WAIT_INT;
          end else if (step_q == STEP_FIRST && err_q) begin
            // TCR=0 issued after an abort: that is the whole shutdown.
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + STEP_ONE;
            req     = 1'b1;
            state_d = ST_SETUP;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_INT: begin
        // The interrupt takes priority over a same-cycle abort.
        if (tim_int) begin
          step_d  = STEP_CLR;
          req     = 1'b1;
          state_d = ST_SETUP;
        end else if (abort) begin
          err_d   = 1'b1;
          step_d  = STEP_FIRST;
          req     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_FIRST;
      cmp_q   <= '0;
      den_q   <= 1'b0;
      dval_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cmp_q   <= cmp_d;
      den_q   <= den_d;
      dval_q  <= dval_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign err  = done & err_q;

endmodule

// File: tb/tb_timer_cfg_seq.sv
// Testbench for timer_cfg_seq: APB slave model plus transfer scoreboard.
module tb_timer_cfg_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] cmp_val = '0;
  logic        div_en = 1'b0;
  logic [3:0]  div_val = '0;
  logic        busy, done, err;
  logic        tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata = '0;
  logic        tim_pready = 1'b0;
  logic        tim_pslverr = 1'b0;
  logic        tim_int = 1'b0;

  timer_cfg_seq #(.TO_W(4)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .abort       (abort),
    .cmp_val     (cmp_val),
    .div_en      (div_en),
    .div_val     (div_val),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .tim_psel    (tim_psel),
    .tim_penable (tim_penable),
    .tim_pwrite  (tim_pwrite),
    .tim_paddr   (tim_paddr),
    .tim_pwdata  (tim_pwdata),
    .tim_pstrb   (tim_pstrb),
    .tim_prdata  (tim_prdata),
    .tim_pready  (tim_pready),
    .tim_pslverr (tim_pslverr),
    .tim_int     (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          ws_cfg[16];
  int          slverr_step = -1;
  bit          stuck = 1'b0;
  int          xfer_n = 0;
  int          acc = 0;
  int          last_acc = 0;
  bit          stable = 1'b1;
  logic [11:0] a0 = '0;
  logic [31:0] w0 = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference step table for the timer programming sequence.
  function automatic xfer_t model_step(input int s, input logic [63:0] c,
                                       input logic de, input logic [3:0] dv);
    xfer_t x;
    x.wr   = 1'b1;
    x.data = 32'h0;
    x.addr = 12'h000;
    case (s)
      1: x.addr = 12'h004;
      2: x.addr = 12'h008;
      3: begin x.addr = 12'h00C; x.data = c[31:0];  end
      4: begin x.addr = 12'h010; x.data = c[63:32]; end
      5: begin x.addr = 12'h018; x.data = 32'h1; end
      6: begin x.addr = 12'h014; x.data = 32'h1; end
      7: begin x.addr = 12'h000; x.data = {20'h0, dv, 6'h0, de, 1'b1}; end
      8: begin x.addr = 12'h018; x.data = 32'h1; end
      9: begin x.addr = 12'h018; x.wr = 1'b0; end
      default: ;
    endcase
    return x;
  endfunction

  // One clock: advance to the falling edge, then run the APB slave model
  // and check each completing transfer against the scoreboard.
  task automatic tick();
    xfer_t e;
    @(negedge sys_clk);
    if (!busy) xfer_n = 0;
    if (tim_psel && tim_penable) begin
      acc++;
      if (acc == 1) begin
        a0 = tim_paddr; w0 = tim_pwdata; stable = 1'b1;
      end else if (tim_paddr !== a0 || tim_pwdata !== w0) begin
        stable = 1'b0;
      end
      if (!stuck && xfer_n < 16 && acc > ws_cfg[xfer_n]) begin
        tim_pready  = 1'b1;
        tim_pslverr = (xfer_n == slverr_step);
        if (exp_q.size() == 0) begin
          check_val("xfer_q_size", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          check_val("paddr", 64'(tim_paddr), 64'(e.addr));
          check_val("pwrite", 64'(tim_pwrite), 64'(e.wr));
          check_val("pstrb", 64'(tim_pstrb), e.wr ? 64'hF : 64'h0);
          if (e.wr) check_val("pwdata", 64'(tim_pwdata), 64'(e.data));
          check_val("stable", 64'(stable), 64'(1));
          check_val("access_cycles", 64'(acc), 64'(ws_cfg[xfer_n] + 1));
        end
        xfer_n++;
      end else begin
        tim_pready  = 1'b0;
        tim_pslverr = 1'b0;
      end
    end else begin
      if (acc != 0) last_acc = acc;
      acc         = 0;
      tim_pready  = 1'b0;
      tim_pslverr = 1'b0;
    end
  endtask

  task automatic do_start(input logic [63:0] c, input logic de, input logic [3:0] dv);
    cmp_val = c; div_en = de; div_val = dv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_wint();
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy && !tim_psel && !done) begin got = 1'b1; break; end
    end
    check_val("reach_wait_int", 64'(got), 64'(1));
    check_val("q_empty_wint", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_done(input logic exp_err);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        check_val("err", 64'(err), 64'(exp_err));
        check_val("psel_at_done", 64'(tim_psel), 64'(0));
        break;
      end
    end
    check_val("done_seen", 64'(got), 64'(1));
    check_val("q_empty_done", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    tick();
    check_val("busy_after_done", 64'(busy), 64'(0));
    check_val("done_pulse", 64'(done), 64'(0));
  endtask

  task automatic push_arm(input logic [63:0] c, input logic de, input logic [3:0] dv);
    for (int s = 0; s < 8; s++) exp_q.push_back(model_step(s, c, de, dv));
  endtask

  task automatic run_arm(input logic [63:0] c, input logic de, input logic [3:0] dv);
    push_arm(c, de, dv);
    do_start(c, de, dv);
    wait_wint();
  endtask

  task automatic finish_int(input logic [31:0] rd, input logic exp_err);
    exp_q.push_back(model_step(8, '0, 1'b0, 4'h0));
    exp_q.push_back(model_step(9, '0, 1'b0, 4'h0));
    tim_prdata = rd;
    tim_int = 1'b1;
    tick();
    tim_int = 1'b0;
    wait_done(exp_err);
    tim_prdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ws_cfg[i] = 0;
    tick();
    tick();
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    check_val("rst_err", 64'(err), 64'(0));
    check_val("rst_psel", 64'(tim_psel), 64'(0));
    check_val("rst_penable", 64'(tim_penable), 64'(0));
    check_val("rst_paddr", 64'(tim_paddr), 64'(0));
    check_val("rst_pstrb", 64'(tim_pstrb), 64'(0));
    sys_rst_n = 1'b1;
    tick();

    // Nominal sequence
    run_arm(64'h0000_0001_0000_0010, 1'b1, 4'd2);
    check_val("busy_in_wait", 64'(busy), 64'(1));
    finish_int(32'h0, 1'b0);

    // Wait states on step 3
    ws_cfg[3] = 3;
    run_arm(64'hDEAD_BEEF_1234_5678, 1'b0, 4'd9);
    finish_int(32'h0, 1'b0);
    ws_cfg[3] = 0;

    // Slave error on step 4
    slverr_step = 4;
    for (int s = 0; s < 5; s++) exp_q.push_back(model_step(s, 64'hA5A5_0000_0000_5A5A, 1'b1, 4'd1));
    do_start(64'hA5A5_0000_0000_5A5A, 1'b1, 4'd1);
    wait_done(1'b1);
    slverr_step = -1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("idle_after_slverr", 64'(tim_psel), 64'(0));
    end

    // Timeout with pready stuck low
    stuck = 1'b1;
    do_start(64'h5, 1'b0, 4'd0);
    wait_done(1'b1);
    check_val("timeout_access_cycles", 64'(last_acc), 64'(15));
    stuck = 1'b0;

    // Abort in WAIT_INT
    run_arm(64'h0000_0000_0000_0100, 1'b1, 4'd3);
    exp_q.push_back(model_step(0, '0, 1'b0, 4'h0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(1'b1);

    // Interrupt and abort together: interrupt wins
    run_arm(64'h0000_0002_0000_0002, 1'b0, 4'd4);
    exp_q.push_back(model_step(8, '0, 1'b0, 4'h0));
    exp_q.push_back(model_step(9, '0, 1'b0, 4'h0));
    tim_int = 1'b1;
    abort = 1'b1;
    tick();
    tim_int = 1'b0;
    abort = 1'b0;
    wait_done(1'b0);

    // Status still set on read-back
    run_arm(64'h0000_0000_0000_0040, 1'b1, 4'd15);
    finish_int(32'h0000_0001, 1'b1);

    // start while busy is ignored
    push_arm(64'h1111_2222_3333_4444, 1'b1, 4'd6);
    do_start(64'h1111_2222_3333_4444, 1'b1, 4'd6);
    tick();
    tick();
    cmp_val = 64'hFFFF_FFFF_FFFF_FFFF; div_en = 1'b0; div_val = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_wint();
    finish_int(32'h0, 1'b0);

    // Asynchronous reset during ACCESS
    stuck = 1'b1;
    do_start(64'h7, 1'b1, 4'd1);
    for (int i = 0; i < 10; i++) begin
      if (tim_penable) break;
      tick();
    end
    check_val("reach_access", 64'(tim_penable), 64'(1));
    #2 sys_rst_n = 1'b0;
    #1;
    check_val("arst_psel", 64'(tim_psel), 64'(0));
    check_val("arst_penable", 64'(tim_penable), 64'(0));
    check_val("arst_busy", 64'(busy), 64'(0));
    check_val("arst_paddr_pwdata", {20'h0, tim_paddr, tim_pwdata}, 64'(0));
    check_val("arst_pstrb", 64'(tim_pstrb), 64'(0));
    tick();
    stuck = 1'b0;
    sys_rst_n = 1'b1;
    tick();
    check_val("post_arst_busy", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
